debug_controller: RTL and testbench
===================================

# debug_controller

CPU-side sequencer directly downstream of `debugPort`. Consumes the pending-command request (`DEBUG_REQX`, `DEBUG_OPX`, `DEBUG_ARGX`), halts and steps the core, and runs memory and register accesses on the debug bus. Produces the completion strobes back into `debugPort`: `DEBUG_ACKX`, `DEBUG_DOUT_LDX`, `DEBUG_DATAX`, `DEBUG_ADDR_LDX` and `DEBUG_ADDR_INCX`.

## Interface
- `STEP_TIMEOUT`, default 255: maximum cycles spent waiting for `CPU_INSTR_DONE`.
- `MEM_LATENCY`, default 1: cycles from a `DEBUG_MEM_RD` pulse until memory read data is valid on `DEBUG_DIN_DIN`.
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `DEBUG_REQX` in 1: level; a command is pending in `debugPort`.
- `DEBUG_OPX` in 3: command opcode.
- `DEBUG_ARGX` in 4: command argument.
- `CPU_INSTR_DONE` in 1: one-cycle pulse at every instruction boundary.
- `DEBUG_ACKX` out 1: one-cycle command-complete pulse.
- `DEBUG_DOUT_LDX` out 1: one-cycle pulse; `debugPort` latches the selected 16-bit source.
- `DEBUG_DATAX` out 2: selects the `debugPort` data source.
- `DEBUG_ADDR_LDX` out 1: loads the `debugPort` address counter from MAH/MAL.
- `DEBUG_ADDR_INCX` out 1: advances the `debugPort` address counter by one word.
- `DEBUG_HALT` out 1: stalls the core fetch.
- `DEBUG_BUS_EN` out 1: debug port owns the memory bus.
- `DEBUG_MEM_RD` out 1: one-cycle memory read strobe.
- `DEBUG_MEM_WR` out 1: one-cycle memory write strobe.
- `DEBUG_REG_SEL` out 4: register-file port B index.
- `DEBUG_ERR` out 1: one-cycle pulse, issued together with `DEBUG_ACKX`, when a command was rejected.

## Operation
- **Opcodes** (`constants.v`):
  - NONE=0, STOP=1, RUN=2, STEP=3, RD_MEM=4, WR_MEM=5, RD_REG=6; 7 is reserved.
- **Data-source selects** (`DEBUG_DATAX`):
  - DIN=0, REGB_DATA=1, CC_DATA=2, PC_A_NEXT=3.
- **FSM states:** IDLE, WAIT_HALT, ADDR, MEM, MEM_WAIT, STEP_WAIT, ACK, GUARD.
- **IDLE**
  - When `DEBUG_REQX`=1, latch `DEBUG_OPX` and `DEBUG_ARGX`, then decode.
  - NONE and reserved: go to ACK with no effect; reserved also raises `DEBUG_ERR`.
- **STOP**
  - Go to WAIT_HALT.
  - Set `DEBUG_HALT` on the first `CPU_INSTR_DONE`.
  - If the core is already halted, go straight to ACK.
- **RUN**
  - Clear `DEBUG_HALT`, then ACK.
- **STEP** (halted only)
  - Clear `DEBUG_HALT` and enter STEP_WAIT.
  - On `CPU_INSTR_DONE`, set `DEBUG_HALT` in the same cycle, then ACK.
  - If the counter reaches `STEP_TIMEOUT`, set `DEBUG_HALT`, then ACK with `DEBUG_ERR`.
- **RD_MEM / WR_MEM** (halted only)
  - ADDR: `DEBUG_ADDR_LDX`=1 and `DEBUG_BUS_EN`=1.
  - MEM: pulse `DEBUG_MEM_RD` or `DEBUG_MEM_WR`.
  - RD_MEM then waits `MEM_LATENCY` cycles in MEM_WAIT, and ACK pulses `DEBUG_DOUT_LDX` with DATAX=DIN.
  - If `ARGX[0]`=1, ACK also pulses `DEBUG_ADDR_INCX`.
- **RD_REG** (halted only)
  - `ARGX` 0..13: `DEBUG_REG_SEL`=`ARGX`, DATAX=REGB_DATA.
  - `ARGX` 14: DATAX=CC_DATA.
  - `ARGX` 15: DATAX=PC_A_NEXT.
  - Hold the select for one cycle, then ACK with `DEBUG_DOUT_LDX`.
- **Halted-only commands while running:** ACK with `DEBUG_ERR` and no bus or register activity.
- **GUARD**
  - One cycle in which `DEBUG_REQX` is ignored, covering `debugPort`'s REQX deassert latency.
  - Always returns to IDLE.

## Timing
- **Reset values:**
  - All outputs are 0; state is IDLE and the core is running.
  - A reset arriving mid-command aborts it: `DEBUG_BUS_EN` drops on the next edge and no ACK is issued.
- **Handshake:**
  - ACK is exactly one cycle.
  - `DEBUG_DOUT_LDX` is coincident with ACK.
  - `DEBUG_DATAX` is stable from the decode cycle through ACK.
- **Latency from `DEBUG_REQX` sampled high to ACK:**
  - RD_REG: 2 cycles.
  - WR_MEM: 3 cycles.
  - RD_MEM: 3+`MEM_LATENCY` cycles.
  - RUN, NONE and rejected commands: 1 cycle.
- **Bus ownership:** `DEBUG_BUS_EN` is high from ADDR through ACK inclusive.
- **Address order:** `DEBUG_ADDR_LDX` precedes the memory strobe by one cycle.
- **STOP:** `CPU_INSTR_DONE` coincident with the decode cycle halts immediately.
- **Back-to-back commands:** `DEBUG_REQX` still high in GUARD is not accepted before IDLE.
- **Step counter:** 8 bits; saturates at `STEP_TIMEOUT`, never wraps.

## Structure
- Opcode and DATAX constants live in the shared `constants.v`, next to the existing `DEBUG_OPX_*` and `DEBUG_DATAX_*` defines.
- State encodings stay local.
- One natural sub-module: `debugStepTimer`, the saturating counter with clear and expired output.

## Test plan
- Reset, then sample → all outputs 0 and `DEBUG_HALT`=0.
- STOP request, `CPU_INSTR_DONE` 3 cycles later → `DEBUG_HALT` rises on that pulse; one ACK; GUARD ignores the held `DEBUG_REQX`.
- Halted, RD_REG with `ARGX`=5 → `DEBUG_REG_SEL`=5, DATAX=1, ACK and `DEBUG_DOUT_LDX` on cycle 2.
- Halted, RD_REG with `ARGX`=15 → DATAX=3.
- Halted, WR_MEM with `ARGX`=1 → LDX, then `DEBUG_MEM_WR`, then ACK with `DEBUG_ADDR_INCX`; `DEBUG_BUS_EN` is high for exactly those 3 cycles.
- Halted, RD_MEM with `MEM_LATENCY`=2 → ACK and `DEBUG_DOUT_LDX` with DATAX=0 at cycle 5.
- Running, then RD_MEM → ACK and `DEBUG_ERR` in cycle 1; no bus activity.
- Halted, STEP with no `CPU_INSTR_DONE` → ACK and `DEBUG_ERR` after 255 cycles; `DEBUG_HALT` ends at 1.
- `RESET` asserted in MEM_WAIT → IDLE on the next edge; no ACK; `DEBUG_BUS_EN`=0.

Source files
------------

// File: rtl/debug_controller_pkg.sv
// Shared opcode and data-source encodings for the debug command sequencer.
package debug_controller_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpStop  = 3'd1,
    OpRun   = 3'd2,
    OpStep  = 3'd3,
    OpRdMem = 3'd4,
    OpWrMem = 3'd5,
    OpRdReg = 3'd6,
    OpRsvd  = 3'd7
  } debug_op_e;

  typedef enum logic [1:0] {
    DataDin    = 2'd0,
    DataRegb   = 2'd1,
    DataCc     = 2'd2,
    DataPcNext = 2'd3
  } debug_data_e;

  localparam int unsigned StepCntW = 8;

  function automatic logic op_needs_halt(debug_op_e op);
    return op inside {OpStep, OpRdMem, OpWrMem, OpRdReg};
  endfunction

endpackage

// File: rtl/debug_controller_step_timer.sv
// Saturating step-wait counter; expired fires in the cycle the count reaches Limit.
module debug_controller_step_timer
  import debug_controller_pkg::*;
#(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [StepCntW-1:0] LimitW = StepCntW'(Limit);

  logic [StepCntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LimitW)) begin
      count_d = count_q + 1'b1;
    end
    expired = en && (count_d == LimitW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/debug_controller.sv
// Debug command sequencer: halts/steps the core and runs bus/register accesses for debugPort.
module debug_controller
  import debug_controller_pkg::*;
#(
  parameter int unsigned STEP_TIMEOUT = 255,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DEBUG_REQX,
  input  logic [2:0] DEBUG_OPX,
  input  logic [3:0] DEBUG_ARGX,
  input  logic       CPU_INSTR_DONE,
  output logic       DEBUG_ACKX,
  output logic       DEBUG_DOUT_LDX,
  output logic [1:0] DEBUG_DATAX,
  output logic       DEBUG_ADDR_LDX,
  output logic       DEBUG_ADDR_INCX,
  output logic       DEBUG_HALT,
  output logic       DEBUG_BUS_EN,
  output logic       DEBUG_MEM_RD,
  output logic       DEBUG_MEM_WR,
  output logic [3:0] DEBUG_REG_SEL,
  output logic       DEBUG_ERR
);

  typedef enum logic [3:0] {
    StIdle, StWaitHalt, StAddr, StMem, StMemWait, StRegRd, StStepWait, StAck, StGuard
  } state_e;

  localparam logic [7:0] LatLimit = 8'(MEM_LATENCY);

  state_e      state_q, state_d;
  debug_op_e   op_q, op_d, op_in;
  debug_data_e datax_q, datax_d;
  logic [3:0]  reg_sel_q, reg_sel_d;
  logic [7:0]  lat_q, lat_d;
  logic        inc_q, inc_d, err_q, err_d, halt_q, halt_d;
  logic        halt_now, mem_op, tmr_clr, tmr_en, tmr_expired;

  assign op_in  = debug_op_e'(DEBUG_OPX);
  assign mem_op = (op_q == OpRdMem) || (op_q == OpWrMem);

  debug_controller_step_timer #(
    .Limit(STEP_TIMEOUT)
  ) u_step_timer (
    .clk    (CLK),
    .reset  (RESET),
    .clear  (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    datax_d         = datax_q;
    reg_sel_d       = reg_sel_q;
    lat_d           = lat_q;
    inc_d           = inc_q;
    err_d           = err_q;
    halt_d          = halt_q;
    halt_now        = 1'b0;
    tmr_clr         = (state_q != StStepWait);
    tmr_en          = (state_q == StStepWait);
    DEBUG_ACKX      = 1'b0;
    DEBUG_DOUT_LDX  = 1'b0;
    DEBUG_ADDR_LDX  = 1'b0;
    DEBUG_ADDR_INCX = 1'b0;
    DEBUG_BUS_EN    = 1'b0;
    DEBUG_MEM_RD    = 1'b0;
    DEBUG_MEM_WR    = 1'b0;
    DEBUG_ERR       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (DEBUG_REQX) begin
          op_d  = op_in;
          inc_d = DEBUG_ARGX[0];
          err_d = 1'b0;
          if (op_needs_halt(op_in) && !halt_q) begin
            err_d   = 1'b1;
            state_d = StAck;
          end else begin
            case (op_in)
              OpStop: begin
                if (halt_q) begin
                  state_d = StAck;
                end else if (CPU_INSTR_DONE) begin
                  halt_now = 1'b1;
                  halt_d   = 1'b1;
                  state_d  = StAck;
                end else begin
                  state_d = StWaitHalt;
                end
              end
              OpRun: begin
                halt_d  = 1'b0;
                state_d = StAck;
              end
              OpStep: begin
                halt_d  = 1'b0;
                state_d = StStepWait;
              end
              OpRdMem, OpWrMem: begin
                datax_d = DataDin;
                state_d = StAddr;
              end
              OpRdReg: begin
                if (DEBUG_ARGX < 4'd14) begin
                  reg_sel_d = DEBUG_ARGX;
                  datax_d   = DataRegb;
                end else if (DEBUG_ARGX == 4'd14) begin
                  datax_d = DataCc;
                end else begin
                  datax_d = DataPcNext;
                end
                state_d = StRegRd;
              end
              OpRsvd: begin
                err_d   = 1'b1;
                state_d = StAck;
              end
              default: state_d = StAck;
            endcase
          end
        end
      end
      StWaitHalt: begin
        if (CPU_INSTR_DONE) begin
          halt_now = 1'b1;
          halt_d   = 1'b1;
          state_d  = StAck;
        end
      end
      StStepWait: begin
        // Halt must assert on the boundary itself so the next fetch is stalled.
        if (CPU_INSTR_DONE) begin
          halt_now = 1'b1;
          halt_d   = 1'b1;
          state_d  = StAck;
        end else if (tmr_expired) begin
          halt_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAddr: begin
        DEBUG_ADDR_LDX = 1'b1;
        DEBUG_BUS_EN   = 1'b1;
        state_d        = StMem;
      end
      StMem: begin
        DEBUG_BUS_EN = 1'b1;
        if (op_q == OpRdMem) begin
          DEBUG_MEM_RD = 1'b1;
          if (LatLimit == 8'd0) begin
            state_d = StAck;
          end else begin
            lat_d   = 8'd1;
            state_d = StMemWait;
          end
        end else begin
          DEBUG_MEM_WR = 1'b1;
          state_d      = StAck;
        end
      end
      StMemWait: begin
        DEBUG_BUS_EN = 1'b1;
        if (lat_q >= LatLimit) begin
          state_d = StAck;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      StRegRd: state_d = StAck;
      StAck: begin
        DEBUG_ACKX      = 1'b1;
        DEBUG_ERR       = err_q;
        DEBUG_BUS_EN    = mem_op && !err_q;
        DEBUG_DOUT_LDX  = !err_q && ((op_q == OpRdMem) || (op_q == OpRdReg));
        DEBUG_ADDR_INCX = mem_op && !err_q && inc_q;
        state_d         = StGuard;
      end
      StGuard: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign DEBUG_HALT    = halt_q | halt_now;
  assign DEBUG_DATAX   = datax_q;
  assign DEBUG_REG_SEL = reg_sel_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      op_q      <= OpNone;
      datax_q   <= DataDin;
      reg_sel_q <= '0;
      lat_q     <= '0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      datax_q   <= datax_d;
      reg_sel_q <= reg_sel_d;
      lat_q     <= lat_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
      halt_q    <= halt_d;
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller; expected ACK records are queued per command.
module tb_debug_controller;

  localparam logic [2:0] OpNone = 3'd0, OpStop = 3'd1, OpRun = 3'd2, OpStep = 3'd3;
  localparam logic [2:0] OpRdMem = 3'd4, OpWrMem = 3'd5, OpRdReg = 3'd6, OpRsvd = 3'd7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reqx = 1'b0;
  logic [2:0] opx = 3'd0;
  logic [3:0] argx = 4'd0;
  logic       instr_done = 1'b0;
  logic       ackx, dout_ldx, addr_ldx, addr_incx, halt, bus_en, mem_rd, mem_wr, err;
  logic [1:0] datax;
  logic [3:0] reg_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0, bus_cnt = 0, rd_cnt = 0, wr_cnt = 0;

  typedef struct {
    string      tag;
    int         lat;
    logic       err;
    logic       dout;
    logic [1:0] datax;
    logic       inc;
    logic       halt;
    logic       bus;
  } exp_t;

  exp_t sb[$];

  debug_controller #(
    .STEP_TIMEOUT(255),
    .MEM_LATENCY (2)
  ) dut (
    .CLK            (clk),
    .RESET          (reset),
    .DEBUG_REQX     (reqx),
    .DEBUG_OPX      (opx),
    .DEBUG_ARGX     (argx),
    .CPU_INSTR_DONE (instr_done),
    .DEBUG_ACKX     (ackx),
    .DEBUG_DOUT_LDX (dout_ldx),
    .DEBUG_DATAX    (datax),
    .DEBUG_ADDR_LDX (addr_ldx),
    .DEBUG_ADDR_INCX(addr_incx),
    .DEBUG_HALT     (halt),
    .DEBUG_BUS_EN   (bus_en),
    .DEBUG_MEM_RD   (mem_rd),
    .DEBUG_MEM_WR   (mem_wr),
    .DEBUG_REG_SEL  (reg_sel),
    .DEBUG_ERR      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ack_cnt <= ack_cnt + int'(ackx);
    bus_cnt <= bus_cnt + int'(bus_en);
    rd_cnt  <= rd_cnt + int'(mem_rd);
    wr_cnt  <= wr_cnt + int'(mem_wr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ack(input string tag, input int lat, input logic e, input logic d,
                            input logic [1:0] dx, input logic inc, input logic h, input logic b);
    exp_t x;
    x.tag = tag; x.lat = lat; x.err = e; x.dout = d; x.datax = dx;
    x.inc = inc; x.halt = h; x.bus = b;
    sb.push_back(x);
  endtask

  // Drives the request so it is sampled on the next edge; returns in cycle 1.
  task automatic issue(input logic [2:0] op, input logic [3:0] arg, input bit hold);
    reqx = 1'b1; opx = op; argx = arg;
    tick();
    if (!hold) reqx = 1'b0;
  endtask

  task automatic wait_ack(input int start);
    int   lat;
    exp_t x;
    lat = start;
    while (!ackx && lat < 600) begin
      tick();
      lat++;
    end
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, "_lat"}, 32'(lat), 32'(x.lat));
      check({x.tag, "_err"}, 32'(err), 32'(x.err));
      check({x.tag, "_dout"}, 32'(dout_ldx), 32'(x.dout));
      check({x.tag, "_datax"}, 32'(datax), 32'(x.datax));
      check({x.tag, "_inc"}, 32'(addr_incx), 32'(x.inc));
      check({x.tag, "_halt"}, 32'(halt), 32'(x.halt));
      check({x.tag, "_bus"}, 32'(bus_en), 32'(x.bus));
    end
  endtask

  initial begin
    int a0, b0, r0, w0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", {ackx, dout_ldx, datax, addr_ldx, addr_incx, halt, bus_en, mem_rd,
                            mem_wr, reg_sel, err}, 32'd0);
    check("reset_halt", 32'(halt), 32'd0);

    // Halted-only command while running is rejected without bus activity.
    b0 = bus_cnt; r0 = rd_cnt;
    expect_ack("rej_rdmem", 1, 1, 0, 2'd0, 0, 0, 0);
    issue(OpRdMem, 4'd1, 0);
    wait_ack(1);
    tick(); tick();
    check("rej_bus_cycles", 32'(bus_cnt - b0), 32'd0);
    check("rej_rd_strobes", 32'(rd_cnt - r0), 32'd0);

    // STOP with the instruction boundary arriving three cycles later; REQX held through GUARD.
    a0 = ack_cnt;
    expect_ack("stop", 4, 0, 0, 2'd0, 0, 1, 0);
    issue(OpStop, 4'd0, 1);
    tick();
    check("stop_halt_pre", 32'(halt), 32'd0);
    tick();
    instr_done = 1'b1;
    #1;
    check("stop_halt_on_pulse", 32'(halt), 32'd1);
    tick();
    instr_done = 1'b0;
    wait_ack(4);
    tick(); tick();
    reqx = 1'b0;
    repeat (3) tick();
    check("stop_guard_single_ack", 32'(ack_cnt - a0), 32'd1);

    expect_ack("stop_halted", 1, 0, 0, 2'd0, 0, 1, 0);
    issue(OpStop, 4'd0, 0);
    wait_ack(1);
    tick(); tick();

    expect_ack("rdreg5", 2, 0, 1, 2'd1, 0, 1, 0);
    issue(OpRdReg, 4'd5, 0);
    check("rdreg5_datax_c1", 32'(datax), 32'd1);
    wait_ack(1);
    check("rdreg5_sel", 32'(reg_sel), 32'd5);
    tick(); tick();

    expect_ack("rdreg15", 2, 0, 1, 2'd3, 0, 1, 0);
    issue(OpRdReg, 4'd15, 0);
    wait_ack(1);
    tick(); tick();

    expect_ack("rdreg14", 2, 0, 1, 2'd2, 0, 1, 0);
    issue(OpRdReg, 4'd14, 0);
    wait_ack(1);
    tick(); tick();

    b0 = bus_cnt; w0 = wr_cnt; r0 = rd_cnt;
    expect_ack("wrmem", 3, 0, 0, 2'd0, 1, 1, 1);
    issue(OpWrMem, 4'd1, 0);
    check("wrmem_addr_ld", 32'(addr_ldx), 32'd1);
    check("wrmem_wr_early", 32'(mem_wr), 32'd0);
    tick();
    check("wrmem_wr", 32'(mem_wr), 32'd1);
    check("wrmem_addr_ld_off", 32'(addr_ldx), 32'd0);
    wait_ack(2);
    tick(); tick();
    check("wrmem_bus_cycles", 32'(bus_cnt - b0), 32'd3);
    check("wrmem_wr_strobes", 32'(wr_cnt - w0), 32'd1);
    check("wrmem_rd_strobes", 32'(rd_cnt - r0), 32'd0);

    r0 = rd_cnt;
    expect_ack("rdmem", 5, 0, 1, 2'd0, 0, 1, 1);
    issue(OpRdMem, 4'd0, 0);
    wait_ack(1);
    tick(); tick();
    check("rdmem_rd_strobes", 32'(rd_cnt - r0), 32'd1);

    expect_ack("step_timeout", 256, 1, 0, 2'd0, 0, 1, 0);
    issue(OpStep, 4'd0, 0);
    check("step_halt_released", 32'(halt), 32'd0);
    wait_ack(1);
    tick(); tick();
    check("step_timeout_halt_after", 32'(halt), 32'd1);

    expect_ack("step_done", 5, 0, 0, 2'd0, 0, 1, 0);
    issue(OpStep, 4'd0, 0);
    tick(); tick(); tick();
    instr_done = 1'b1;
    #1;
    check("step_halt_same_cycle", 32'(halt), 32'd1);
    tick();
    instr_done = 1'b0;
    wait_ack(5);
    tick(); tick();

    expect_ack("run", 1, 0, 0, 2'd0, 0, 0, 0);
    issue(OpRun, 4'd0, 0);
    wait_ack(1);
    tick(); tick();

    // STOP whose decode cycle coincides with an instruction boundary.
    expect_ack("stop_decode", 1, 0, 0, 2'd0, 0, 1, 0);
    reqx = 1'b1; opx = OpStop; argx = 4'd0; instr_done = 1'b1;
    #1;
    check("stop_decode_halt", 32'(halt), 32'd1);
    tick();
    reqx = 1'b0; instr_done = 1'b0;
    wait_ack(1);
    tick(); tick();

    expect_ack("reserved", 1, 1, 0, 2'd0, 0, 1, 0);
    issue(OpRsvd, 4'd0, 0);
    wait_ack(1);
    tick(); tick();

    expect_ack("none", 1, 0, 0, 2'd0, 0, 1, 0);
    issue(OpNone, 4'd0, 0);
    wait_ack(1);
    tick(); tick();

    // Reset while RD_MEM sits in MEM_WAIT aborts without an ACK.
    issue(OpRdMem, 4'd0, 0);
    tick(); tick();
    check("rst_bus_pre", 32'(bus_en), 32'd1);
    a0 = ack_cnt;
    reset = 1'b1;
    tick();
    check("rst_bus_drop", 32'(bus_en), 32'd0);
    check("rst_no_ack", 32'(ackx), 32'd0);
    check("rst_running", 32'(halt), 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("rst_ack_count", 32'(ack_cnt - a0), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
